sprite_pixel_compositor: RTL and testbench

- Downstream consumer of the sprite finder's four-candidate result: `active_high_four` plus `high_four01..04`, with `01` the highest priority.
- For the current pixel (`H_pos_in`/`V_pos_in`), it fetches each candidate's 16x16 bitmap texel from sprite memory in priority order.
- It emits the first non-transparent colour, or the background colour if none, as one registered pixel to the VGA output stage.
- It keeps its own per-sprite anchor/bitmap table, loaded through a config write port by the same function processor that positions sprites.

---
 rtl/sprite_pixel_compositor_pkg.sv | 15 +
 rtl/sprite_pixel_compositor_table.sv | 35 +++
 rtl/sprite_pixel_compositor.sv | 109 ++++++++++
 tb/tb_sprite_pixel_compositor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sprite_pixel_compositor_pkg.sv
// sprite_pixel_compositor_pkg: shared constants, address layout and FSM encoding for the compositor
package sprite_pixel_compositor_pkg;
  localparam int COLOR_W = 9;
  localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 9'h000;
  localparam int ID_W = 6;
  localparam logic [ID_W-1:0] NO_SPRITE_ID = 6'h3F;
  localparam int NUM_SPRITES = 32;
  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int POS_W = 10;
  localparam int SPRITE_SIZE = 16;
  localparam int SPRITE_LOG2 = 4;
  localparam int BITMAP_W = 5;
  localparam int ADDR_W = BITMAP_W + 2 * SPRITE_LOG2;
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
endpackage

// File: rtl/sprite_pixel_compositor_table.sv
// sprite_anchor_table: per-sprite anchor/bitmap register file, one sync write port, one async read port
module sprite_anchor_table
  import sprite_pixel_compositor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ID_W-1:0]     wr_id,
  input  logic [POS_W-1:0]    wr_x,
  input  logic [POS_W-1:0]    wr_y,
  input  logic [BITMAP_W-1:0] wr_bitmap,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [POS_W-1:0]    rd_x,
  output logic [POS_W-1:0]    rd_y,
  output logic [BITMAP_W-1:0] rd_bitmap
);
  logic [POS_W-1:0]    x_q [NUM_SPRITES];
  logic [POS_W-1:0]    y_q [NUM_SPRITES];
  logic [BITMAP_W-1:0] bm_q [NUM_SPRITES];
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        bm_q[i] <= '0;
      end
    else if (wr_en && wr_id < ID_W'(NUM_SPRITES)) begin
      x_q[wr_id[IDX_W-1:0]]  <= wr_x;
      y_q[wr_id[IDX_W-1:0]]  <= wr_y;
      bm_q[wr_id[IDX_W-1:0]] <= wr_bitmap;
    end
  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];
  assign rd_bitmap = bm_q[rd_idx];
endmodule

// File: rtl/sprite_pixel_compositor.sv
// sprite_pixel_compositor: walks four priority-ordered sprite candidates and emits the first opaque texel or background
module sprite_pixel_compositor
  import sprite_pixel_compositor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               active_high_four,
  input  logic [5:0]         high_four01,
  input  logic [5:0]         high_four02,
  input  logic [5:0]         high_four03,
  input  logic [5:0]         high_four04,
  input  logic [9:0]         H_pos_in,
  input  logic [9:0]         V_pos_in,
  input  logic [8:0]         bg_color,
  input  logic               cfg_wr_en,
  input  logic [5:0]         cfg_id,
  input  logic [9:0]         cfg_anchor_x,
  input  logic [9:0]         cfg_anchor_y,
  input  logic [4:0]         cfg_bitmap,
  output logic               mem_rd_en,
  output logic [12:0]        mem_addr,
  input  logic [8:0]         mem_rd_data,
  output logic               pixel_valid,
  output logic [8:0]         pixel_rgb,
  output logic               busy,
  output logic               overrun
);
  state_t state, next_state;
  logic [1:0] slot;
  logic [ID_W-1:0] ids [4];
  logic [POS_W-1:0] h, v, ax, ay, dx, dy;
  logic [COLOR_W-1:0] bg, emit_rgb;
  logic [BITMAP_W-1:0] bm;
  logic [ID_W-1:0] cur_id;
  logic hit, opaque, emit, adv, last;
  sprite_anchor_table u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_wr_en),
    .wr_id    (cfg_id),
    .wr_x     (cfg_anchor_x),
    .wr_y     (cfg_anchor_y),
    .wr_bitmap(cfg_bitmap),
    .rd_idx   (cur_id[IDX_W-1:0]),
    .rd_x     (ax),
    .rd_y     (ay),
    .rd_bitmap(bm)
  );
  assign cur_id = ids[slot];
  assign dx     = h - ax;
  assign dy     = v - ay;
  assign last   = slot == 2'd3;
  assign opaque = mem_rd_data != TRANSPARENT_COLOR;
  // dx/dy wrap when the pixel is left of or above the anchor, so the explicit compares are needed too
  assign hit = cur_id != NO_SPRITE_ID && cur_id < ID_W'(NUM_SPRITES) && h >= ax && v >= ay &&
               dx < POS_W'(SPRITE_SIZE) && dy < POS_W'(SPRITE_SIZE);
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_rgb   = bg;
    adv        = 1'b0;
    case (state)
      IDLE:  next_state = active_high_four ? ISSUE : IDLE;
      ISSUE: begin
        emit       = !hit && last;
        adv        = !hit && !last;
        next_state = hit ? CHECK : last ? IDLE : ISSUE;
      end
      CHECK: begin
        emit       = opaque || last;
        emit_rgb   = opaque ? mem_rd_data : bg;
        adv        = !opaque && !last;
        next_state = emit ? IDLE : ISSUE;
      end
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    mem_rd_en = state == ISSUE && hit;
    mem_addr  = {bm, dy[SPRITE_LOG2-1:0], dx[SPRITE_LOG2-1:0]};
    busy      = state != IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      slot        <= '0;
      pixel_valid <= 1'b0;
      pixel_rgb   <= '0;
      overrun     <= 1'b0;
    end else begin
      pixel_valid <= emit;
      if (emit) pixel_rgb <= emit_rgb;
      if (adv) slot <= slot + 2'd1;
      if (state == IDLE && active_high_four) slot <= '0;
      if (state != IDLE && active_high_four) overrun <= 1'b1;
    end
  always_ff @(posedge clk)
    if (state == IDLE && active_high_four) begin
      ids[0] <= high_four01;
      ids[1] <= high_four02;
      ids[2] <= high_four03;
      ids[3] <= high_four04;
      h      <= H_pos_in;
      v      <= V_pos_in;
      bg     <= bg_color;
    end
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// tb_sprite_pixel_compositor: directed vectors with hand-computed pixels, addresses and latencies
module tb_sprite_pixel_compositor;
  logic clk, rst, active_high_four, cfg_wr_en, mem_rd_en, pixel_valid, busy, overrun;
  logic [5:0] high_four01, high_four02, high_four03, high_four04, cfg_id;
  logic [9:0] H_pos_in, V_pos_in, cfg_anchor_x, cfg_anchor_y;
  logic [8:0] bg_color, mem_rd_data, pixel_rgb;
  logic [4:0] cfg_bitmap;
  logic [12:0] mem_addr;
  logic [8:0] mem [8192];
  int checks = 0, errors = 0;
  sprite_pixel_compositor dut (
    .clk(clk), .rst(rst), .active_high_four(active_high_four),
    .high_four01(high_four01), .high_four02(high_four02), .high_four03(high_four03), .high_four04(high_four04),
    .H_pos_in(H_pos_in), .V_pos_in(V_pos_in), .bg_color(bg_color),
    .cfg_wr_en(cfg_wr_en), .cfg_id(cfg_id), .cfg_anchor_x(cfg_anchor_x), .cfg_anchor_y(cfg_anchor_y),
    .cfg_bitmap(cfg_bitmap), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb), .busy(busy), .overrun(overrun)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) mem_rd_data <= mem[mem_addr];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [5:0] id, input logic [9:0] x, y, input logic [4:0] b);
    cfg_wr_en = 1; cfg_id = id; cfg_anchor_x = x; cfg_anchor_y = y; cfg_bitmap = b;
    next_cycle();
    cfg_wr_en = 0;
  endtask
  task automatic start(input logic [5:0] a, b, c, d, input logic [9:0] h, v, input logic [8:0] bg);
    active_high_four = 1;
    high_four01 = a; high_four02 = b; high_four03 = c; high_four04 = d;
    H_pos_in = h; V_pos_in = v; bg_color = bg;
  endtask
  task automatic collect(input int t0, output int lat, output int reads, output logic [12:0] a1, output logic [8:0] rgb);
    lat = -1; reads = 0; a1 = '0; rgb = '0;
    for (int t = t0; t < t0 + 20 && lat < 0; t++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (reads == 0) a1 = mem_addr;
        reads++;
      end
      if (pixel_valid) begin
        lat = t;
        rgb = pixel_rgb;
      end
      next_cycle();
      active_high_four = 0;
    end
  endtask
  task automatic pixel(input string tag, input logic [5:0] a, b, c, d, input logic [9:0] h, v,
                       input logic [8:0] bg, input int e_lat, e_reads, e_a1, e_rgb);
    int lat, reads;
    logic [12:0] a1;
    logic [8:0] rgb;
    start(a, b, c, d, h, v, bg);
    collect(0, lat, reads, a1, rgb);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " reads"}, reads, e_reads);
    if (e_reads > 0) check({tag, " addr"}, int'(a1), e_a1);
    check({tag, " rgb"}, int'(rgb), e_rgb);
  endtask
  initial begin
    int lat, reads, pv_seen;
    logic [12:0] a1;
    logic [8:0] rgb;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h075] = 9'h123;
    mem[13'h275] = 9'h1C0;
    mem[13'h211] = 9'h0F0;
    mem[13'h2FF] = 9'h1FF;
    mem[13'h575] = 9'h0C3;
    rst = 0; active_high_four = 0; cfg_wr_en = 0;
    start(6'h3F, 6'h3F, 6'h3F, 6'h3F, 0, 0, 0);
    active_high_four = 0;
    cfg_id = 0; cfg_anchor_x = 0; cfg_anchor_y = 0; cfg_bitmap = 0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset pixel_valid", int'(pixel_valid), 0);
    check("reset pixel_rgb", int'(pixel_rgb), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset busy", int'(busy), 0);
    next_cycle();
    rst = 1;
    next_cycle();
    pixel("zero table", 6'd3, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h011, 3, 1, 13'h075, 9'h123);
    cfg(6'd3, 100, 50, 5'd2);
    cfg(6'd4, 100, 50, 5'd1);
    pixel("basic", 6'd3, 6'h3F, 6'h3F, 6'h3F, 105, 57, 9'h011, 3, 1, 13'h275, 9'h1C0);
    pixel("priority", 6'd4, 6'd3, 6'h3F, 6'h3F, 101, 51, 9'h011, 5, 2, 13'h111, 9'h0F0);
    pixel("all empty", 6'h3F, 6'h3F, 6'h3F, 6'h3F, 101, 51, 9'h049, 5, 0, 0, 9'h049);
    pixel("dx 16", 6'd3, 6'h3F, 6'h3F, 6'h3F, 116, 57, 9'h0AA, 5, 0, 0, 9'h0AA);
    pixel("left of anchor", 6'd3, 6'h3F, 6'h3F, 6'h3F, 99, 57, 9'h0AB, 5, 0, 0, 9'h0AB);
    pixel("dy 16", 6'd3, 6'h3F, 6'h3F, 6'h3F, 105, 66, 9'h0AC, 5, 0, 0, 9'h0AC);
    pixel("corner 15", 6'd3, 6'h3F, 6'h3F, 6'h3F, 115, 65, 9'h0AD, 3, 1, 13'h2FF, 9'h1FF);
    pixel("id 32", 6'd32, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h0AE, 5, 0, 0, 9'h0AE);
    pixel("all transparent", 6'd4, 6'd4, 6'd4, 6'd4, 101, 51, 9'h0AF, 9, 4, 13'h111, 9'h0AF);
    start(6'd3, 6'h3F, 6'h3F, 6'h3F, 105, 57, 9'h0AA);
    next_cycle();
    high_four01 = 6'h3F;
    next_cycle();
    active_high_four = 0;
    @(negedge clk);
    check("overrun set", int'(overrun), 1);
    check("overrun busy", int'(busy), 1);
    next_cycle();
    start(6'h3F, 6'h3F, 6'h3F, 6'h3F, 0, 0, 9'h155);
    @(negedge clk);
    check("overrun pv", int'(pixel_valid), 1);
    check("overrun rgb", int'(pixel_rgb), 9'h1C0);
    next_cycle();
    active_high_four = 0;
    collect(1, lat, reads, a1, rgb);
    check("overlap latency", lat, 5);
    check("overlap rgb", int'(rgb), 9'h155);
    check("overrun sticky", int'(overrun), 1);
    start(6'd3, 6'h3F, 6'h3F, 6'h3F, 105, 57, 9'h011);
    next_cycle();
    active_high_four = 0;
    cfg_wr_en = 1; cfg_id = 6'd3; cfg_anchor_x = 0; cfg_anchor_y = 0; cfg_bitmap = 5'd5;
    @(negedge clk);
    check("old anchor rd_en", int'(mem_rd_en), 1);
    check("old anchor addr", int'(mem_addr), 13'h275);
    next_cycle();
    cfg_wr_en = 0;
    collect(2, lat, reads, a1, rgb);
    check("old anchor latency", lat, 3);
    check("old anchor rgb", int'(rgb), 9'h1C0);
    pixel("new anchor", 6'd3, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h011, 3, 1, 13'h575, 9'h0C3);
    cfg(6'd35, 200, 200, 5'd7);
    pixel("dropped write", 6'd3, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h011, 3, 1, 13'h575, 9'h0C3);
    start(6'd3, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h011);
    next_cycle();
    active_high_four = 0;
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("pre-reset busy", int'(busy), 1);
    next_cycle();
    rst = 1;
    pv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      pv_seen += int'(pixel_valid);
      next_cycle();
    end
    check("abandoned pv", pv_seen, 0);
    check("abandoned overrun", int'(overrun), 0);
    check("abandoned busy", int'(busy), 0);
    pixel("cleared table", 6'd3, 6'h3F, 6'h3F, 6'h3F, 5, 7, 9'h011, 3, 1, 13'h075, 9'h123);
    pixel("cleared sprite 4", 6'd4, 6'h3F, 6'h3F, 6'h3F, 101, 51, 9'h022, 5, 0, 0, 9'h022);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
